an_decode_ctrl_n29: RTL and testbench
=====================================

// Module: an_decode_ctrl_n29
// PURPOSE
//  Sequencer/arbiter for the shared A=29 AN-code decode datapath. Two requesters
//  present 14-bit codewords; the block arbitrates round-robin, computes the residue
//  codeword mod 29 by pipelined Barrett reduction and applies the residue to one shared
//  an_decoder_n29 instance. It returns the 10-bit message, source tag and
//  correction flag over a valid/ready output port. Decoding is non-pipelined: one codeword in flight.
// PARAMETERS
//  A      29    AN-code multiplier; fixed to match an_decoder_n29
//  CW_W   14    codeword width
//  MSG_W  10    message width
//  BR_K   15    Barrett shift
//  BR_M   1129  Barrett constant, floor(2^BR_K / A)
//  CNT_W  16    correction-counter width (ERR_COUNT_EN only)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous reset, active-high
//  in0_valid  in   1      requester 0 codeword valid
//  in0_ready  out  1      requester 0 accepted
//  in0_cw     in   CW_W   requester 0 codeword
//  in1_valid  in   1      requester 1 codeword valid
//  in1_ready  out  1      requester 1 accepted
//  in1_cw     in   CW_W   requester 1 codeword
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  out_msg    out  MSG_W  decoded message
//  out_src    out  1      requester index of result
//  out_corr   out  1      1 = residue nonzero (single-bit error corrected)
//  out_res    out  5      residue applied to decoder
//  busy       out  1      high in every state except IDLE
//  err_cnt    out  CNT_W  corrections counter (ERR_COUNT_EN only)
// BEHAVIOUR
//  - Reset (async, rst=1): state IDLE, out_valid=0, out_msg=0, out_src=0, out_corr=0,
//    out_res=0, busy=0, rr pointer favours requester 0, err_cnt=0.
//    Reset mid-operation discards the in-flight codeword. No partial result is presented.
//  - FSM: IDLE -> RED1 -> RED2 -> DEC -> OUT -> IDLE. Each state lasts 1 cycle, except OUT.
//  - IDLE: inN_ready is combinational and high only for the granted requester.
//    Both valid: grant the requester not granted last. One valid: grant it.
//    On handshake, capture cw and src, flip the rr pointer to the other requester, go to RED1.
//    Both readys are low outside IDLE.
//  - RED1: q = (cw*BR_M) >> BR_K, registered; product width CW_W+11 bits.
//  - RED2: r = cw - q*A, 6 bits, range 0..57. If r >= A, r -= A. Register r[4:0].
//  - DEC: drive an_decoder_n29 with (cw, r). Register its message into out_msg.
//    Set out_res=r and out_corr=(r!=0). Go to OUT with out_valid=1.
//  - OUT: hold all outputs stable while out_valid & !out_ready.
//    On out_valid & out_ready, clear out_valid and go to IDLE. A new grant is possible the next cycle.
//  - Latency: input handshake in cycle T gives out_valid at T+4. Throughput: 1 result per 5 cycles
//    at most (out_ready tied high).
//  - Every nonzero residue 1..28 maps to a single error of +-2^i; the decoder corrects all of them.
//    Residue 0 means a clean codeword. Codewords with q > 564 are outside the message range.
//    The result is then the decoder output truncated to MSG_W; no error is flagged.
//  - busy = (state != IDLE).
// CONFIGURATION
//  ERR_COUNT_EN defined:
//    - err_cnt increments by 1 on each output handshake with out_corr=1.
//    - err_cnt saturates at 2^CNT_W-1 and clears only on rst.
//  ERR_COUNT_EN undefined: the err_cnt port and its counter are absent; all other behaviour is identical.
// TESTING
//  1 in0_cw=145 (29*5), out_ready=1 -> out_valid 4 cycles after handshake; msg=5, res=0, corr=0, src=0.
//  2 in1_cw=144 (bit0 flipped) -> msg=5, res=28, corr=1, src=1.
//    in1_cw=2904 -> msg=100, res=4, corr=1.
//  3 in0/in1 both valid and held -> grants alternate 0,1,0,1.
//    Never two readys in one cycle; every result carries the correct src.
//  4 out_ready=0 for 6 cycles in OUT -> outputs held stable; no in*_ready.
//    Raising out_ready gives handshake, then IDLE.
//  5 in0_cw=16383 -> Barrett gives q=564, res=27. Also sweep all 565 clean codewords k*29
//    and all their single-bit flips: msg=k every time.
//  6 rst pulse during RED2 -> out_valid=0 and busy=0 immediately. The next codeword
//    decodes normally. With ERR_COUNT_EN: err_cnt=0 after reset, counts 3 after 3 corrected results.

Source files
------------

// File: rtl/an_decode_ctrl_n29.sv
// an_decode_ctrl_n29: round-robin sequencer for the shared A=29 AN-code decoder (Barrett residue, one codeword in flight).
// Define ERR_COUNT_EN to add the saturating err_cnt corrections counter port.
module an_decoder_n29 (
  input  logic [13:0] cw,
  input  logic [4:0]  res,
  output logic [9:0]  msg
);
  logic signed [15:0] e, fix;
  always_comb begin
    e = '0;
    // 2 has order 28 mod 29, so every nonzero residue is exactly one of +2^i or -2^i
    for (int i = 0; i < 14; i++) begin
      if (5'((1 << i) % 29) == res) e = 16'(1 << i);
      if (5'(29 - (1 << i) % 29) == res) e = -16'(1 << i);
    end
    fix = $signed({2'b0, cw}) - e;
    msg = 10'(fix / 16'sd29);
  end
endmodule

module an_decode_ctrl_n29 #(
  parameter int A     = 29,
  parameter int CW_W  = 14,
  parameter int MSG_W = 10,
  parameter int BR_K  = 15,
  parameter int BR_M  = 1129,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [CW_W-1:0]  in0_cw,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [CW_W-1:0]  in1_cw,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MSG_W-1:0] out_msg,
  output logic             out_src,
  output logic             out_corr,
  output logic [4:0]       out_res,
  output logic             busy
`ifdef ERR_COUNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt
`endif
);
  localparam int Q_W = CW_W + 11 - BR_K;
  typedef enum logic [2:0] {IDLE, RED1, RED2, DEC, OUT} state_t;
  state_t state, state_nx;
  logic rr, src_q, g0, g1;
  logic [CW_W-1:0] cw_q;
  logic [CW_W+10:0] prod;
  logic [Q_W-1:0] q_q;
  logic [5:0] t;
  logic [4:0] r_q, r_nx;
  logic [MSG_W-1:0] dec_msg;

  // rr=1 favours requester 1
  assign g1 = in1_valid & (rr | ~in0_valid);
  assign g0 = in0_valid & ~g1;
  assign prod = cw_q * (CW_W + 11)'(BR_M);
  assign t = 6'(cw_q - CW_W'(q_q) * CW_W'(A));
  assign r_nx = t >= 6'(A) ? 5'(t - 6'(A)) : t[4:0];

  an_decoder_n29 u_dec (.cw(cw_q), .res(r_q), .msg(dec_msg));

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state == IDLE ? ((g0 | g1) ? RED1 : IDLE) :
               state == RED1 ? RED2 :
               state == RED2 ? DEC :
               state == DEC  ? OUT :
               (out_ready ? IDLE : OUT);
  end

  always_comb begin
    busy = state != IDLE;
    out_valid = state == OUT;
    in0_ready = state == IDLE && g0;
    in1_ready = state == IDLE && g1;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rr <= 1'b0;
      src_q <= 1'b0;
      cw_q <= '0;
      q_q <= '0;
      r_q <= '0;
      out_msg <= '0;
      out_src <= 1'b0;
      out_corr <= 1'b0;
      out_res <= '0;
    end else begin
      if (in0_ready | in1_ready) begin
        cw_q <= in1_ready ? in1_cw : in0_cw;
        src_q <= in1_ready;
        rr <= ~in1_ready;
      end
      if (state == RED1) q_q <= Q_W'(prod >> BR_K);
      if (state == RED2) r_q <= r_nx;
      if (state == DEC) begin
        out_msg <= dec_msg;
        out_src <= src_q;
        out_corr <= r_q != '0;
        out_res <= r_q;
      end
    end

`ifdef ERR_COUNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) err_cnt <= '0;
    else if (out_valid && out_ready && out_corr && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_an_decode_ctrl_n29.sv
// tb_an_decode_ctrl_n29: scoreboard bench with an arithmetic reference decoder and round-robin model.
module tb_an_decode_ctrl_n29;
  logic clk = 0, rst = 1, in0_valid = 0, in1_valid = 0, out_ready = 1;
  logic [13:0] in0_cw = 0, in1_cw = 0;
  logic in0_ready, in1_ready, out_valid, out_src, out_corr, busy;
  logic [9:0] out_msg;
  logic [4:0] out_res;
`ifdef ERR_COUNT_EN
  logic [15:0] err_cnt;
`endif

  always #5 clk = ~clk;

  an_decode_ctrl_n29 dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_cw(in0_cw),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_cw(in1_cw),
    .out_valid(out_valid), .out_ready(out_ready), .out_msg(out_msg),
    .out_src(out_src), .out_corr(out_corr), .out_res(out_res), .busy(busy)
`ifdef ERR_COUNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  typedef struct {logic [9:0] msg; logic src; logic corr; logic [4:0] res; int t;} exp_t;
  exp_t sb[$];
  int vectors = 0, miscompares = 0, cyc = 0, m_err = 0, rdy_mode = 0;
  bit mrr = 0, prev_ov = 0, prev_rd = 0;
  int held = 0;
  logic [9:0] last_msg = 0;
  logic last_src = 0, last_corr = 0;
  logic [4:0] last_res = 0;

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Decode by searching for the single +-2^i error that makes the word a multiple of 29
  function automatic exp_t model(int cw, bit src, int t);
    exp_t e;
    int m = cw / 29;
    for (int i = 0; i < 14; i++) begin
      if ((cw - (1 << i)) % 29 == 0) m = (cw - (1 << i)) / 29;
      if ((cw + (1 << i)) % 29 == 0) m = (cw + (1 << i)) / 29;
    end
    e.msg = 10'(m);
    e.res = 5'(cw % 29);
    e.corr = (cw % 29) != 0;
    e.src = src;
    e.t = t;
    return e;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) out_ready = 1;
    else if (rdy_mode == 1) out_ready = 1'($urandom % 2);
  end

  always @(negedge clk) if (!rst) begin
    exp_t e;
    bit g;
    chk("one_ready", int'(in0_ready && in1_ready), 0);
    if (busy) chk("ready_busy", int'(in0_ready || in1_ready), 0);
    if (!busy && (in0_valid || in1_valid)) begin
      g = (in0_valid && in1_valid) ? mrr : in1_valid;
      chk("grant", int'({in1_ready, in0_ready}), g ? 2 : 1);
      sb.push_back(model(g ? int'(in1_cw) : int'(in0_cw), g, cyc));
      mrr = !g;
    end
    if (out_valid && prev_ov && !prev_rd)
      chk("hold", int'({out_msg, out_src, out_corr, out_res}), held);
    if (out_valid && !prev_ov) begin
      if (sb.size() == 0) chk("unexpected_valid", 1, 0);
      else chk("latency", cyc - sb[0].t, 4);
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("spurious_out", 1, 0);
      else begin
        e = sb.pop_front();
        chk("msg", int'(out_msg), int'(e.msg));
        chk("src", int'(out_src), int'(e.src));
        chk("corr", int'(out_corr), int'(e.corr));
        chk("res", int'(out_res), int'(e.res));
`ifdef ERR_COUNT_EN
        chk("err_cnt", int'(err_cnt), m_err);
        if (e.corr && m_err < 65535) m_err++;
`endif
      end
      last_msg = out_msg; last_src = out_src; last_corr = out_corr; last_res = out_res;
    end
    prev_ov = out_valid;
    prev_rd = out_ready;
    held = int'({out_msg, out_src, out_corr, out_res});
  end

  task automatic send(bit v0, bit v1, logic [13:0] c0, logic [13:0] c1);
    bit a0, a1;
    in0_cw = c0; in1_cw = c1; in0_valid = v0; in1_valid = v1;
    for (int n = 0; n < 100 && (in0_valid || in1_valid); n++) begin
      @(negedge clk);
      a0 = in0_valid && in0_ready;
      a1 = in1_valid && in1_ready;
      @(posedge clk); #1;
      if (a0) in0_valid = 0;
      if (a1) in1_valid = 0;
    end
    if (in0_valid || in1_valid) begin
      chk("send_timeout", 1, 0);
      in0_valid = 0; in1_valid = 0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("drain_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_msg", int'(out_msg), 0);
    chk("rst_src", int'(out_src), 0);
    chk("rst_corr", int'(out_corr), 0);
    chk("rst_res", int'(out_res), 0);
`ifdef ERR_COUNT_EN
    chk("rst_err_cnt", int'(err_cnt), 0);
`endif
    rst = 0;
    #1 chk("idle_no_ready", int'({in1_ready, in0_ready}), 0);
    @(posedge clk); #1;

    send(1, 0, 14'd145, 0); drain();
    chk("k145_msg", int'(last_msg), 5); chk("k145_res", int'(last_res), 0);
    chk("k145_corr", int'(last_corr), 0); chk("k145_src", int'(last_src), 0);
    send(0, 1, 0, 14'd144); drain();
    chk("k144_msg", int'(last_msg), 5); chk("k144_res", int'(last_res), 28);
    chk("k144_corr", int'(last_corr), 1); chk("k144_src", int'(last_src), 1);
    send(0, 1, 0, 14'd2904); drain();
    chk("k2904_msg", int'(last_msg), 100); chk("k2904_res", int'(last_res), 4);
    chk("k2904_corr", int'(last_corr), 1);
    send(1, 0, 14'd16383, 0); drain();
    chk("kmax_res", int'(last_res), 27);

    // both requesters held: grants must alternate
    in0_cw = 14'($urandom); in1_cw = 14'($urandom); in0_valid = 1; in1_valid = 1;
    for (int n = 0, g = 0; g < 8 && n < 200; n++) begin
      bit a0, a1;
      @(negedge clk);
      a0 = in0_ready; a1 = in1_ready;
      @(posedge clk); #1;
      if (a0) in0_cw = 14'($urandom);
      if (a1) in1_cw = 14'($urandom);
      g += int'(a0) + int'(a1);
      if (n == 199) chk("alt_timeout", 1, 0);
    end
    in0_valid = 0; in1_valid = 0;
    drain();

    // backpressure in OUT with a pending requester
    rdy_mode = 2; out_ready = 0;
    send(1, 0, 14'($urandom), 0);
    for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
    chk("bp_valid", int'(out_valid), 1);
    in0_cw = 14'($urandom); in0_valid = 1;
    repeat (6) @(negedge clk);
    @(posedge clk); #1 out_ready = 1;
    @(posedge clk); #1;
    chk("bp_released", int'(out_valid), 0);
    chk("bp_idle", int'(busy), 0);
    @(posedge clk); #1 in0_valid = 0;
    rdy_mode = 0; drain();

    // asynchronous reset while the codeword sits in RED2
    send(1, 0, 14'($urandom), 0);
    @(posedge clk); #2 rst = 1;
    #1;
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_busy", int'(busy), 0);
    sb.delete(); mrr = 0; m_err = 0; prev_ov = 0;
`ifdef ERR_COUNT_EN
    chk("arst_err_cnt", int'(err_cnt), 0);
`endif
    @(posedge clk); #1 rst = 0;
    send(0, 1, 0, 14'd144); drain();
    chk("post_rst_msg", int'(last_msg), 5); chk("post_rst_src", int'(last_src), 1);
    send(1, 0, 14'd2904, 0); drain();
    send(1, 0, 14'd146, 0); drain();
`ifdef ERR_COUNT_EN
    chk("err_cnt_3", int'(err_cnt), 3);
`endif

    // every clean codeword and each of its single-bit flips
    for (int k = 0; k < 565; k++)
      for (int b = -1; b < 14; b++) begin
        logic [13:0] c = 14'(k * 29);
        if (b >= 0) c[b] = ~c[b];
        if ($urandom % 2) send(1, 0, c, 0); else send(0, 1, 0, c);
      end
    drain();

    rdy_mode = 1;
    repeat (300) begin
      bit v0 = 1'($urandom % 2);
      bit v1 = v0 ? 1'($urandom % 2) : 1'b1;
      send(v0, v1, 14'($urandom), 14'($urandom));
    end
    rdy_mode = 0; drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
